// File: rtl/execute_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
// master is the upstream/observer side; slave is the execute stage itself.
interface execute_if;
  logic        i_con_regdst;
  logic        i_con_alusrc;
  logic        i_con_branch;
  logic        i_con_memread;
  logic        i_con_memwrite;
  logic        i_con_memtoreg;
  logic        i_con_regwrite;
  logic [1:0]  i_con_aluop;
  logic [31:0] i_addr_NextPC;
  logic [31:0] i_data_rs;
  logic [31:0] i_data_rt;
  logic [31:0] i_data_SignExt;
  logic [4:0]  i_addr_mux_0;
  logic [4:0]  i_addr_mux_1;

  logic        o_con_stall;
  logic        o_con_mem_branch;
  logic        o_con_mem_memread;
  logic        o_con_mem_memwrite;
  logic        o_con_wb_memtoreg;
  logic        o_con_wb_regwrite;
  logic        o_con_zero;
  logic [31:0] o_addr_BranchPC;
  logic [31:0] o_data_ALUResult;
  logic [31:0] o_data_WrMem;
  logic [4:0]  o_addr_WrReg;

  modport master (
    output i_con_regdst, i_con_alusrc, i_con_branch, i_con_memread,
           i_con_memwrite, i_con_memtoreg, i_con_regwrite, i_con_aluop,
           i_addr_NextPC, i_data_rs, i_data_rt, i_data_SignExt,
           i_addr_mux_0, i_addr_mux_1,
    input  o_con_stall, o_con_mem_branch, o_con_mem_memread,
           o_con_mem_memwrite, o_con_wb_memtoreg, o_con_wb_regwrite,
           o_con_zero, o_addr_BranchPC, o_data_ALUResult, o_data_WrMem,
           o_addr_WrReg
  );

  modport slave (
    input  i_con_regdst, i_con_alusrc, i_con_branch, i_con_memread,
           i_con_memwrite, i_con_memtoreg, i_con_regwrite, i_con_aluop,
           i_addr_NextPC, i_data_rs, i_data_rt, i_data_SignExt,
           i_addr_mux_0, i_addr_mux_1,
    output o_con_stall, o_con_mem_branch, o_con_mem_memread,
           o_con_mem_memwrite, o_con_wb_memtoreg, o_con_wb_regwrite,
           o_con_zero, o_addr_BranchPC, o_data_ALUResult, o_data_WrMem,
           o_addr_WrReg
  );
endinterface

// File: rtl/execute.sv
// MIPS execute stage: ALU, branch-target add, iterative 32-cycle HI/LO
// multiplier with pipeline stall, and the EX/MEM pipeline register.
module execute (
  input  logic     i_clk,
  input  logic     i_rst,
  execute_if.slave ex
);
  typedef enum logic {S_IDLE, S_BUSY} mstate_t;
  typedef enum logic [3:0] {
    A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_NOR, A_SLT, A_SLTU,
    A_MFHI, A_MFLO, A_MULT, A_MULTU, A_NOP
  } alu_op_t;

  mstate_t     state, state_nxt;
  alu_op_t     op;
  logic        busy, mul_done, is_mult, mul_signed, neg_nxt, neg;
  logic [4:0]  cnt;
  logic [5:0]  funct;
  logic [31:0] opb, result, hi, lo, mcand, abs_rs, abs_rt;
  logic [32:0] psum;
  logic [63:0] prod, prod_nxt, prod_final;

  assign funct = ex.i_data_SignExt[5:0];
  assign opb   = ex.i_con_alusrc ? ex.i_data_SignExt : ex.i_data_rt;

  always_comb begin
    op = A_NOP;
    case (ex.i_con_aluop)
      2'b01: op = A_SUB;
      2'b10: begin
        case (funct)
          6'h20, 6'h21: op = A_ADD;
          6'h22, 6'h23: op = A_SUB;
          6'h24:        op = A_AND;
          6'h25:        op = A_OR;
          6'h26:        op = A_XOR;
          6'h27:        op = A_NOR;
          6'h2A:        op = A_SLT;
          6'h2B:        op = A_SLTU;
          6'h10:        op = A_MFHI;
          6'h12:        op = A_MFLO;
          6'h18:        op = A_MULT;
          6'h19:        op = A_MULTU;
          default:      op = A_NOP;
        endcase
      end
      default: op = A_ADD;
    endcase
  end

  always_comb begin
    result = '0;
    case (op)
      A_ADD:   result = ex.i_data_rs + opb;
      A_SUB:   result = ex.i_data_rs - opb;
      A_AND:   result = ex.i_data_rs & opb;
      A_OR:    result = ex.i_data_rs | opb;
      A_XOR:   result = ex.i_data_rs ^ opb;
      A_NOR:   result = ~(ex.i_data_rs | opb);
      A_SLT:   result = {31'd0, $signed(ex.i_data_rs) < $signed(opb)};
      A_SLTU:  result = {31'd0, ex.i_data_rs < opb};
      A_MFHI:  result = hi;
      A_MFLO:  result = lo;
      default: result = '0;
    endcase
  end

  // Signed multiply runs on magnitudes; the sign is reapplied on the final edge.
  assign is_mult    = (op == A_MULT) || (op == A_MULTU);
  assign mul_signed = (op == A_MULT);
  assign neg_nxt    = mul_signed & (ex.i_data_rs[31] ^ ex.i_data_rt[31]);
  assign abs_rs     = (mul_signed && ex.i_data_rs[31]) ? (~ex.i_data_rs + 32'd1) : ex.i_data_rs;
  assign abs_rt     = (mul_signed && ex.i_data_rt[31]) ? (~ex.i_data_rt + 32'd1) : ex.i_data_rt;
  assign psum       = {1'b0, prod[63:32]} + {1'b0, (prod[0] ? mcand : 32'd0)};
  assign prod_nxt   = {psum, prod[31:1]};
  assign prod_final = neg ? (~prod_nxt + 64'd1) : prod_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (is_mult)   state_nxt = S_BUSY;
      S_BUSY: if (cnt == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state == S_BUSY);
    mul_done       = busy && (cnt == '0);
    ex.o_con_stall = busy;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      prod  <= '0;
      mcand <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (!busy) begin
      if (is_mult) begin
        cnt   <= 5'd31;
        prod  <= {32'd0, abs_rt};
        mcand <= abs_rs;
        neg   <= neg_nxt;
      end
    end else begin
      prod <= prod_nxt;
      cnt  <= cnt - 5'd1;
      if (mul_done) {hi, lo} <= prod_final;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || busy) begin
      if (i_rst || busy) begin
        ex.o_con_mem_branch   <= 1'b0;
        ex.o_con_mem_memread  <= 1'b0;
        ex.o_con_mem_memwrite <= 1'b0;
        ex.o_con_wb_memtoreg  <= 1'b0;
        ex.o_con_wb_regwrite  <= 1'b0;
        ex.o_con_zero         <= 1'b0;
        ex.o_addr_BranchPC    <= '0;
        ex.o_data_ALUResult   <= '0;
        ex.o_data_WrMem       <= '0;
        ex.o_addr_WrReg       <= '0;
      end
    end else begin
      ex.o_con_mem_branch   <= ex.i_con_branch;
      ex.o_con_mem_memread  <= ex.i_con_memread;
      ex.o_con_mem_memwrite <= ex.i_con_memwrite;
      ex.o_con_wb_memtoreg  <= ex.i_con_memtoreg;
      ex.o_con_wb_regwrite  <= ex.i_con_regwrite & ~is_mult;
      ex.o_con_zero         <= (result == '0);
      ex.o_addr_BranchPC    <= ex.i_addr_NextPC + {ex.i_data_SignExt[29:0], 2'b00};
      ex.o_data_ALUResult   <= result;
      ex.o_data_WrMem       <= ex.i_data_rt;
      ex.o_addr_WrReg       <= ex.i_con_regdst ? ex.i_addr_mux_1 : ex.i_addr_mux_0;
    end
  end
endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage; expected EX/MEM entries are queued
// per clock edge by the driver and checked by an independent monitor.
module tb_execute;
  logic clk;
  logic rst;
  execute_if bus ();

  execute dut (
    .i_clk (clk),
    .i_rst (rst),
    .ex    (bus)
  );

  typedef struct packed {
    logic        stall;
    logic [4:0]  ctrl;   // {branch, memread, memwrite, memtoreg, regwrite}
    logic        zero;
    logic [31:0] res;
    logic [31:0] bpc;
    logic [31:0] wrmem;
    logic [4:0]  wrreg;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input logic st, input logic [4:0] c, input logic z,
                              input logic [31:0] r, input logic [31:0] b,
                              input logic [31:0] w, input logic [4:0] wr);
    exp_t e;
    e = {st, c, z, r, b, w, wr};
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a = {bus.o_con_stall,
         bus.o_con_mem_branch, bus.o_con_mem_memread, bus.o_con_mem_memwrite,
         bus.o_con_wb_memtoreg, bus.o_con_wb_regwrite,
         bus.o_con_zero, bus.o_data_ALUResult, bus.o_addr_BranchPC,
         bus.o_data_WrMem, bus.o_addr_WrReg};
    return a;
  endfunction

  task automatic compare(input string nm, input exp_t a, input exp_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got stall=%0b ctrl=%05b zero=%0b res=%08h bpc=%08h wrmem=%08h wrreg=%0d, want stall=%0b ctrl=%05b zero=%0b res=%08h bpc=%08h wrmem=%08h wrreg=%0d",
               nm, a.stall, a.ctrl, a.zero, a.res, a.bpc, a.wrmem, a.wrreg,
               e.stall, e.ctrl, e.zero, e.res, e.bpc, e.wrmem, e.wrreg);
    end
  endtask

  // Monitor: one EX/MEM entry is presented per clock; compare away from the edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare(nm, sample(), e);
      end
    end
  end

  task automatic set_in(input logic regdst, input logic alusrc, input logic [1:0] aluop,
                        input logic [4:0] ctrl, input logic [31:0] npc,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] sx, input logic [4:0] m0, input logic [4:0] m1);
    bus.i_con_regdst   = regdst;
    bus.i_con_alusrc   = alusrc;
    bus.i_con_aluop    = aluop;
    bus.i_con_branch   = ctrl[4];
    bus.i_con_memread  = ctrl[3];
    bus.i_con_memwrite = ctrl[2];
    bus.i_con_memtoreg = ctrl[1];
    bus.i_con_regwrite = ctrl[0];
    bus.i_addr_NextPC  = npc;
    bus.i_data_rs      = rs;
    bus.i_data_rt      = rt;
    bus.i_data_SignExt = sx;
    bus.i_addr_mux_0   = m0;
    bus.i_addr_mux_1   = m1;
  endtask

  task automatic issue(input string nm, input exp_t e);
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  task automatic bubbles(input string nm, input int n, input bit drops);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      exp_q.push_back(mk(!((k == n) && drops), 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0));
      name_q.push_back($sformatf("%s_bubble%0d", nm, k));
      #1;
    end
  endtask

  task automatic pulse_reset(input string nm);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 compare(nm, sample(), mk(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0));
    #1 rst = 1'b0;
  endtask

  logic [5:0]  fn  [9] = '{6'h20, 6'h2A, 6'h2B, 6'h27, 6'h26, 6'h24, 6'h25, 6'h22, 6'h3F};
  logic [31:0] rres[9] = '{32'h0, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h1,
                           32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0};

  initial begin
    rst = 1'b1;
    set_in(0, 0, 2'b00, 5'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 compare("reset_state", sample(), mk(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0));
    @(negedge clk);
    rst = 1'b0;

    set_in(0, 1, 2'b00, 5'b00001, 32'h200, 32'h10, 32'h1234, 32'hFFFFFFFC, 5'd7, 5'd9);
    issue("add_imm", mk(0, 5'b00001, 0, 32'hC, 32'h1F0, 32'h1234, 5'd7));
    pulse_reset("midcycle_reset");
    issue("add_imm_after_reset", mk(0, 5'b00001, 0, 32'hC, 32'h1F0, 32'h1234, 5'd7));

    set_in(0, 0, 2'b01, 5'b10000, 32'h100, 32'h55, 32'h55, 32'h3, 5'd0, 5'd0);
    issue("beq", mk(0, 5'b10000, 1, 32'h0, 32'h10C, 32'h55, 5'd0));

    set_in(0, 1, 2'b00, 5'b00100, 32'h300, 32'h1000, 32'hDEADBEEF, 32'h8, 5'd3, 5'd4);
    issue("store", mk(0, 5'b00100, 0, 32'h1008, 32'h320, 32'hDEADBEEF, 5'd3));
    set_in(0, 1, 2'b00, 5'b01011, 32'h300, 32'h1000, 32'hDEADBEEF, 32'h8, 5'd3, 5'd4);
    issue("load", mk(0, 5'b01011, 0, 32'h1008, 32'h320, 32'hDEADBEEF, 5'd3));

    set_in(0, 1, 2'b11, 5'b00001, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h4, 5'd6, 5'd1);
    issue("bpc_wrap", mk(0, 5'b00001, 0, 32'h4, 32'hC, 32'h0, 5'd6));
    set_in(0, 0, 2'b01, 5'b00001, 32'h0, 32'h0, 32'h1, 32'h0, 5'd2, 5'd0);
    issue("sub_wrap", mk(0, 5'b00001, 0, 32'hFFFFFFFF, 32'h0, 32'h1, 5'd2));

    for (int i = 0; i < 9; i++) begin
      set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'hFFFFFFFF, 32'h1, {26'd0, fn[i]}, 5'd2, 5'd5);
      issue($sformatf("rtype_%02h", fn[i]),
            mk(0, 5'b00001, rres[i] == 32'd0, rres[i], {24'd0, fn[i], 2'b00}, 32'h1, 5'd5));
    end

    // signed mult, mfhi held for the whole stall
    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'hFFFFFFFE, 32'h3, 32'h18, 5'd2, 5'd5);
    issue("mult", mk(1, 5'b00000, 1, 32'h0, 32'h60, 32'h3, 5'd5));
    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'h7, 32'h9, 32'h10, 5'd2, 5'd8);
    bubbles("mult", 32, 1'b1);
    issue("mfhi_signed", mk(0, 5'b00001, 0, 32'hFFFFFFFF, 32'h40, 32'h9, 5'd8));
    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'h7, 32'h9, 32'h12, 5'd2, 5'd8);
    issue("mflo_signed", mk(0, 5'b00001, 0, 32'hFFFFFFFA, 32'h48, 32'h9, 5'd8));

    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'hFFFFFFFE, 32'h3, 32'h19, 5'd2, 5'd5);
    issue("multu", mk(1, 5'b00000, 1, 32'h0, 32'h64, 32'h3, 5'd5));
    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'h7, 32'h9, 32'h10, 5'd2, 5'd8);
    bubbles("multu", 32, 1'b1);
    issue("mfhi_unsigned", mk(0, 5'b00001, 0, 32'h2, 32'h40, 32'h9, 5'd8));
    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'h7, 32'h9, 32'h12, 5'd2, 5'd8);
    issue("mflo_unsigned", mk(0, 5'b00001, 0, 32'hFFFFFFFA, 32'h48, 32'h9, 5'd8));

    // reset during the tenth cycle of a multiply
    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'hFFFFFFFE, 32'h3, 32'h19, 5'd2, 5'd5);
    issue("mult_aborted", mk(1, 5'b00000, 1, 32'h0, 32'h64, 32'h3, 5'd5));
    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'h7, 32'h9, 32'h12, 5'd2, 5'd8);
    bubbles("mult_aborted", 9, 1'b0);
    pulse_reset("reset_mid_mult");
    issue("mflo_after_reset", mk(0, 5'b00001, 1, 32'h0, 32'h48, 32'h9, 5'd8));
    set_in(1, 0, 2'b10, 5'b00001, 32'h0, 32'h7, 32'h9, 32'h10, 5'd2, 5'd8);
    issue("mfhi_after_reset", mk(0, 5'b00001, 1, 32'h0, 32'h40, 32'h9, 5'd8));

    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
